seq_mag_comparator: RTL and testbench
=====================================

SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request a comparison; sampled only when busy=0.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-009 SHALL have port busy  output  1  comparison in progress; start ignored while high.
REQ-010 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-011 SHALL have port eq  output  1  registered A == B.
REQ-012 SHALL have port ls  output  1  registered A < B.
REQ-013 SHALL have port gr  output  1  registered A > B.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (busy=0) and CMP (busy=1).
REQ-015 In IDLE with start=1 at edge T0, SHALL latch a, b, signed_mode, clear chunk index to 0, enter CMP, and clear done, eq, ls and gr.
REQ-016 In CMP, SHALL compare one CHUNK-bit slice per cycle, MSB-first, at edge T0+1+i for chunk index i (i=0 is most significant).
REQ-017 When signed_mode=1, SHALL invert the MSB of both latched operands in chunk 0 before the comparison; other chunks are compared unsigned.
REQ-018 On the first chunk where the slices differ, SHALL set gr or ls accordingly, pulse done, and return to IDLE at that same edge (early termination).
REQ-019 If chunk NCH-1 is equal, SHALL set eq=1, pulse done, and return to IDLE at edge T0+NCH.
REQ-020 Latency from the start edge to the done edge SHALL be (index of first differing chunk)+1, bounded by 1..NCH cycles.
REQ-021 After done, exactly one of eq/ls/gr SHALL be 1, held until the next accepted start or reset.
REQ-022 done SHALL be high for exactly one cycle per accepted start; busy SHALL be 0 in that cycle, and a start in that cycle SHALL be accepted (back-to-back).
REQ-023 start, a, b and signed_mode changes while busy=1 SHALL be ignored and SHALL NOT affect the result in progress.
REQ-024 With NCH=1, the block SHALL complete in exactly 1 cycle.

Reset
REQ-025 rst=1 SHALL force IDLE immediately, asynchronously, with busy=0, done=0, eq=0, ls=0, gr=0 and the chunk index at 0.
REQ-026 rst asserted mid-CMP SHALL abort the comparison with no done pulse; the first start after rst deasserts SHALL operate normally.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-027 a=b=0x12345678, unsigned, start at T0 -> busy T0..T0+4, done at T0+4, eq=1, ls=0, gr=0.
REQ-028 a=0x80000000, b=0x00000001: unsigned -> done at T0+1, gr=1; signed -> done at T0+1, ls=1.
REQ-029 a=0x12340000, b=0x12350000, unsigned -> done at T0+2, ls=1; results held for 10 idle cycles.
REQ-030 start at T0 (a=5, b=3), then start at T0+1 with a=1, b=9 -> second start ignored; done at T0+4, gr=1; a start in the done cycle is accepted.
REQ-031 rst pulsed at T0+2 of a 4-chunk compare -> busy, done and results all 0 immediately, no done pulse; the next start (a=b=0) -> eq=1 at start+4.
REQ-032 WIDTH=16, CHUNK=16, signed, a=0xFFFF, b=0x0001 -> done at T0+1, ls=1.

Source files
------------

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator
//   Sequential magnitude comparator. Compares two WIDTH-bit operands one
//   CHUNK-bit slice per cycle, most significant slice first, and stops at
//   the first slice that differs. Supports unsigned and two's-complement
//   compares.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-high reset
//   start        : request a comparison (sampled only while busy=0)
//   signed_mode  : 1 = two's-complement compare, 0 = unsigned (sampled with start)
//   a, b         : operands (sampled with start)
//   busy         : comparison in progress, start ignored while high
//   done         : one-cycle pulse, eq/ls/gr valid from this cycle on
//   eq, ls, gr   : registered A==B, A<B, A>B; held until next accepted start
module seq_mag_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             ls,
    output logic             gr
);

    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic {
        S_IDLE,
        S_CMP
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;

    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_diff;
    logic             w_last;

    // The slice under comparison is always the top CHUNK bits: the latched
    // operands are shifted left by one slice after every equal slice.
    always_comb begin
        w_ca   = r_a[WIDTH-1 -: CHUNK];
        w_cb   = r_b[WIDTH-1 -: CHUNK];
        w_diff = (w_ca != w_cb);
        w_last = (r_idx == LAST_IDX);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_CMP;
            S_CMP:  if (w_diff || w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    assign busy = (r_state == S_CMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            done  <= 1'b0;
            eq    <= 1'b0;
            ls    <= 1'b0;
            gr    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Flipping the sign bit of both operands at capture
                        // turns a signed compare into an unsigned one; only
                        // the top slice is affected.
                        r_a   <= signed_mode ? (a ^ MSB_MASK) : a;
                        r_b   <= signed_mode ? (b ^ MSB_MASK) : b;
                        r_idx <= '0;
                        eq    <= 1'b0;
                        ls    <= 1'b0;
                        gr    <= 1'b0;
                    end
                end
                S_CMP: begin
                    if (w_diff) begin
                        gr   <= (w_ca > w_cb);
                        ls   <= (w_ca < w_cb);
                        done <= 1'b1;
                    end else if (w_last) begin
                        eq   <= 1'b1;
                        done <= 1'b1;
                    end else begin
                        r_a   <= r_a << CHUNK;
                        r_b   <= r_b << CHUNK;
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comparator.sv
module tb_seq_mag_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, eq, ls, gr;

    logic        start1 = 1'b0;
    logic        signed_mode1 = 1'b0;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic        busy1, done1, eq1, ls1, gr1;

    int n_tests = 0;
    int n_fail  = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .ls(ls), .gr(gr)
    );

    seq_mag_comparator #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_mode(signed_mode1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .eq(eq1), .ls(ls1), .gr(gr1)
    );

    // ---------------- behavioural reference model (32/8) ----------------
    // result encoding {gr, ls, eq}
    function automatic logic [2:0] ref_result(input logic [31:0] x, input logic [31:0] y,
                                              input logic sm);
        if (sm) begin
            if ($signed(x) > $signed(y)) return 3'b100;
            if ($signed(x) < $signed(y)) return 3'b010;
            return 3'b001;
        end
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        return 3'b001;
    endfunction

    // cycles from start edge to done edge: index of first differing byte + 1
    function automatic int ref_latency(input logic [31:0] x, input logic [31:0] y);
        for (int i = 0; i < 4; i++) begin
            if (((x >> (24 - 8 * i)) & 32'hFF) != ((y >> (24 - 8 * i)) & 32'hFF))
                return i + 1;
        end
        return 4;
    endfunction

    logic       m_busy, m_done;
    logic [2:0] m_res, m_pend;
    int         m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= 3'b000;
            m_pend <= 3'b000;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_cnt  <= ref_latency(a, b);
                    m_pend <= ref_result(a, b, signed_mode);
                    m_res  <= 3'b000;
                end
            end else if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (check_en) begin
            n_tests++;
            if ({busy, done, gr, ls, eq} !== {m_busy, m_done, m_res}) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t: busy/done/gr/ls/eq got %b%b%b%b%b expected %b%b%b",
                         $time, busy, done, gr, ls, eq, m_busy, m_done, m_res);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // waits (at posedge+1) for done on the 32-bit DUT; k=0 means timeout
    task automatic wait_done(input int maxc, output int k);
        k = 0;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk); #1;
            if (done) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic run32(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tsm, input int exp_lat, input logic [2:0] exp_res);
        int k;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; signed_mode = tsm;
        @(posedge clk); #1;
        check({nm, "_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        // operand noise while busy must not affect the result
        start = 1'b0; a = $urandom; b = $urandom; signed_mode = ~tsm;
        wait_done(8, k);
        check({nm, "_lat"}, k, exp_lat);
        check({nm, "_res"}, {29'd0, gr, ls, eq}, {29'd0, exp_res});
    endtask

    task automatic run16(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tsm, input logic [2:0] exp_res);
        int k;
        @(negedge clk);
        start1 = 1'b1; a1 = ta; b1 = tb_; signed_mode1 = tsm;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; a1 = 16'h5A5A; b1 = 16'hA5A5;
        k = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (done1) begin
                k = c;
                break;
            end
        end
        check({nm, "_lat"}, k, 1);
        check({nm, "_res"}, {29'd0, gr1, ls1, eq1}, {29'd0, exp_res});
    endtask

    initial begin
        int k;
        logic [31:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {27'd0, busy, done, eq, ls, gr}, 32'd0);
        check("reset_outputs_nch1", {27'd0, busy1, done1, eq1, ls1, gr1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;

        // model pinned by hand-computed values
        check("model_lat_eq", ref_latency(32'h12345678, 32'h12345678), 4);
        check("model_res_signed", {29'd0, ref_result(32'h80000000, 32'h1, 1'b1)}, 32'b010);

        run32("eq_all_chunks",  32'h12345678, 32'h12345678, 1'b0, 4, 3'b001);
        run32("unsigned_msb",   32'h80000000, 32'h00000001, 1'b0, 1, 3'b100);
        run32("signed_msb",     32'h80000000, 32'h00000001, 1'b1, 1, 3'b010);
        run32("chunk1_less",    32'h12340000, 32'h12350000, 1'b0, 2, 3'b010);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_ls", {27'd0, busy, done, gr, ls, eq}, 32'b00010);
        end
        run32("signed_neg_eq",  32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 4, 3'b010);

        // start ignored while busy, back-to-back start in done cycle
        @(negedge clk);
        start = 1'b1; a = 32'd5; b = 32'd3; signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 32'd1; b = 32'd9;
        wait_done(8, k);
        check("b2b_first_lat", k, 4);
        check("b2b_first_res", {29'd0, gr, ls, eq}, 32'b100);
        @(posedge clk); #1;
        check("b2b_accept", {30'd0, busy, done}, 32'b10);
        @(negedge clk);
        start = 1'b0;
        wait_done(8, k);
        check("b2b_second_lat", k, 4);
        check("b2b_second_res", {29'd0, gr, ls, eq}, 32'b010);

        // async reset mid-compare
        @(negedge clk);
        start = 1'b1; a = 32'hAAAAAAAA; b = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_rst", {27'd0, busy, done, eq, ls, gr}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        run32("after_rst_eq", 32'd0, 32'd0, 1'b0, 4, 3'b001);

        // single-chunk instance
        run16("nch1_signed",   16'hFFFF, 16'h0001, 1'b1, 3'b010);
        run16("nch1_unsigned", 16'hFFFF, 16'h0001, 1'b0, 3'b100);
        run16("nch1_eq",       16'h8000, 16'h8000, 1'b1, 3'b001);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                2: rb = {ra[31:8], 8'($urandom)};
                3: rb = {ra[31:16], 16'($urandom)};
                default: rb = $urandom;
            endcase
            start = ($urandom_range(0, 3) != 0);
            signed_mode = 1'($urandom);
            a = ra; b = rb;
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
